// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer: shift-add multiply, restoring divide, sign fix-up.
// Optional macro MULDIV_FAST_PATH_EN: divide-by-zero / signed overflow complete in one cycle.
module muldiv_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  func3,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] SIGN = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state;
  logic [2:0]  fn;
  logic        sign_a, sign_b, div_zero, div_ovf;
  logic [4:0]  cnt;
  logic [31:0] hi, lo, mcand;

  logic        signed_a, signed_b, neg_a, neg_b, is_div, zero_in, ovf_in;
  logic [31:0] mag_a, mag_b, fast_result, sign_result;
  logic [32:0] mul_sum, div_trial, div_diff;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  // Accept-time decode: operand signedness, magnitudes and special-case detection.
  always_comb begin
    signed_a    = (func3 == 3'd0) || (func3 == 3'd1) || (func3 == 3'd2) ||
                  (func3 == 3'd4) || (func3 == 3'd6);
    signed_b    = (func3 == 3'd0) || (func3 == 3'd1) || (func3 == 3'd4) || (func3 == 3'd6);
    neg_a       = signed_a && op_a[31];
    neg_b       = signed_b && op_b[31];
    mag_a       = neg_a ? (~op_a + 32'd1) : op_a;
    mag_b       = neg_b ? (~op_b + 32'd1) : op_b;
    is_div      = func3[2];
    zero_in     = is_div && (op_b == 32'd0);
    ovf_in      = is_div && !func3[0] && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
    fast_result = func3[1] ? (zero_in ? op_a : 32'd0)
                           : (zero_in ? 32'hFFFF_FFFF : 32'h8000_0000);
  end

  // One iteration step: hi holds product upper half or partial remainder, lo the multiplier or quotient.
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : 33'd0);
    div_trial = {hi, lo[31]};
    div_diff  = div_trial - {1'b0, mcand};
  end

  // Remainder for divide-by-zero falls out of the iteration as op_a, so only the quotient is forced.
  always_comb begin
    prod_fix = (sign_a ^ sign_b) ? (~{hi, lo} + 64'd1) : {hi, lo};
    quo_fix  = (sign_a ^ sign_b) ? (~lo + 32'd1) : lo;
    rem_fix  = sign_a ? (~hi + 32'd1) : hi;
    case (fn)
      3'd0:          sign_result = prod_fix[31:0];
      3'd1, 3'd2, 3'd3: sign_result = prod_fix[63:32];
      3'd4, 3'd5:    sign_result = div_zero ? 32'hFFFF_FFFF :
                                   div_ovf  ? 32'h8000_0000 : quo_fix;
      default:       sign_result = div_ovf ? 32'd0 : rem_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fn       <= 3'd0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      div_zero <= 1'b0;
      div_ovf  <= 1'b0;
      cnt      <= 5'd0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      mcand    <= 32'd0;
      result   <= 32'd0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
`ifdef MULDIV_FAST_PATH_EN
          if (start && (zero_in || ovf_in)) begin
            result <= fast_result;
            state  <= DONE;
          end else
`endif
          if (start) begin
            fn       <= func3;
            sign_a   <= neg_a;
            sign_b   <= neg_b;
            div_zero <= zero_in;
            div_ovf  <= ovf_in;
            cnt      <= 5'd31;
            hi       <= 32'd0;
            lo       <= is_div ? mag_a : mag_b;
            mcand    <= is_div ? mag_b : mag_a;
            state    <= CALC;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          if (fn[2]) begin
            hi <= div_diff[32] ? div_trial[31:0] : div_diff[31:0];
            lo <= {lo[30:0], ~div_diff[32]};
          end else begin
            {hi, lo} <= {mul_sum, lo[31:1]};
          end
          if (cnt == 5'd0) state <= SIGN;
          else             cnt   <= cnt - 5'd1;
        end
        default: begin
          result <= sign_result;
          state  <= DONE;
        end
      endcase
    end
  end

  assign busy = (state == CALC) || (state == SIGN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq: results, latency, busy length, flush and reset.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  func3;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] result;
  int          errors = 0;
  int          checks = 0;

`ifdef MULDIV_FAST_PATH_EN
  localparam int SPECIAL_LAT  = 1;
  localparam int SPECIAL_BUSY = 0;
`else
  localparam int SPECIAL_LAT  = 34;
  localparam int SPECIAL_BUSY = 33;
`endif

  muldiv_seq dut (
    .clk(clk), .rst(rst), .start(start), .func3(func3), .op_a(op_a), .op_b(op_b),
    .flush(flush), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issues one op from just after an edge and waits (bounded) for done, counting busy cycles.
  task automatic applyStimulus(input string tag, input logic [2:0] f, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp,
                               input int lat, input int expBusy);
    int n;
    int busyCnt;
    func3 = f; op_a = a; op_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    busyCnt = 0;
    while (!done && n < 100) begin
      if (busy) busyCnt++;
      @(posedge clk); #1;
      n++;
    end
    checkOutput({tag, " latency"}, n, lat);
    checkOutput({tag, " busy cycles"}, busyCnt, expBusy);
    checkOutput({tag, " result"}, result, exp);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; start = 1'b0; flush = 1'b0; func3 = 3'd0; op_a = 32'd0; op_b = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset result", result, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Consecutive calls start in the previous done cycle, so these also run back-to-back.
    applyStimulus("MUL 7*-3",     3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 33);
    applyStimulus("MULH",         3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34, 33);
    applyStimulus("MULHSU",       3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, 33);
    applyStimulus("MULHU",        3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 34, 33);
    applyStimulus("DIV -7/2",     3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34, 33);
    applyStimulus("REM -7/2",     3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34, 33);
    applyStimulus("DIVU big/2",   3'd5, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 34, 33);
    applyStimulus("DIVU 5/0",     3'd5, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, SPECIAL_LAT, SPECIAL_BUSY);
    applyStimulus("REM 5/0",      3'd6, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, SPECIAL_LAT, SPECIAL_BUSY);
    applyStimulus("REM -7/0",     3'd6, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, SPECIAL_LAT, SPECIAL_BUSY);
    applyStimulus("DIV -5/0",     3'd4, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFF, SPECIAL_LAT, SPECIAL_BUSY);
    applyStimulus("DIV ovf",      3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPECIAL_LAT, SPECIAL_BUSY);
    applyStimulus("REM ovf",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, SPECIAL_LAT, SPECIAL_BUSY);
    applyStimulus("REMU 100/7",   3'd7, 32'd100,       32'd7,         32'd2,         34, 33);

    @(posedge clk); #1;
    checkOutput("done single pulse", done, 0);
    checkOutput("result held", result, 32'd2);

    // Flush at T+10 of a divide, with a competing start in the same cycle.
    func3 = 3'd4; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    checkOutput("flush busy", busy, 0);
    checkOutput("flush done", done, 0);
    seen = 1'b0;
    repeat (40) begin
      if (done || busy) seen = 1'b1;
      @(posedge clk); #1;
    end
    checkOutput("flush no activity", seen, 0);
    checkOutput("flush result kept", result, 32'd2);
    applyStimulus("MUL 3*4", 3'd0, 32'd3, 32'd4, 32'h0000_000C, 34, 33);

    // Reset at T+20 of MULHU, after an ignored start while busy.
    func3 = 3'd3; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    func3 = 3'd0; op_a = 32'd2; op_b = 32'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("busy after ignored start", busy, 1);
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("mid rst busy", busy, 0);
    checkOutput("mid rst done", done, 0);
    checkOutput("mid rst result", result, 0);
    seen = 1'b0;
    repeat (60) begin
      if (done) seen = 1'b1;
      @(posedge clk); #1;
    end
    checkOutput("no done after rst", seen, 0);
    applyStimulus("DIVU 100/7", 3'd5, 32'd100, 32'd7, 32'd14, 34, 33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle sequencer for the RV32M multiply/divide operations that the single-cycle ALU cannot execute. It sits beside the ALU in the EX stage. It accepts one operation at a time, stalls the pipeline while it iterates, and returns a 32-bit result with a one-cycle `done` pulse. Internally it uses a shift-add multiplier and a restoring divider on magnitudes, with sign correction applied at the end.

## Interface
- Parameters: none; the datapath is fixed at 32 bits and the iteration count at 32.
- Reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  issue request. Sampled only when `busy`=0. Decode drives it high only for M-extension ops (func7 = 0000001).
- `func3`  in  3  op select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `op_a`  in  32  rs1 operand (multiplicand / dividend).
- `op_b`  in  32  rs2 operand (multiplier / divisor).
- `flush`  in  1  abort the in-flight op (branch mispredict / trap).
- `busy`  out  1  high while an op occupies the unit; the hazard unit ORs it into the EX stall.
- `done`  out  1  one-cycle pulse; `result` is valid in this cycle.
- `result`  out  32  final result; holds its value until the next `done`.

## Operation
- States: IDLE, CALC, SIGN, DONE. Reset sets state=IDLE, `busy`=0, `done`=0, `result`=0, and clears all internal registers.
- **Accepting a request (IDLE or DONE):** `start`=1 latches func3 and operand magnitudes and records the operand signs.
  - Signed operands: op_a for MUL, MULH, MULHSU, DIV, REM; op_b for MUL, MULH, DIV, REM.
  - All other operands are treated as unsigned.
  - The iteration counter loads 31 and the state moves to CALC.
- **CALC, multiply:** each cycle, if the multiplier LSB=1, add the multiplicand into the upper half of the 64-bit product. Then shift the product/multiplier right by 1.
- **CALC, divide:** each cycle, shift the {remainder, quotient} pair left by 1 and trial-subtract the divisor from the remainder.
  - If the difference is non-negative, keep it and set the quotient LSB=1.
  - Otherwise, restore the remainder and set the quotient LSB=0.
- CALC leaves to SIGN when counter==0; otherwise the counter decrements.
- **SIGN:**
  - Negate the 64-bit product if sign_a XOR sign_b (signed ops only).
  - Negate the quotient if sign_a XOR sign_b.
  - Negate the remainder if sign_a.
  - Select the result: MUL = product[31:0]; MULH/MULHSU/MULHU = product[63:32]; DIV/DIVU = quotient; REM/REMU = remainder.
  - Load `result` and go to DONE.
- **DONE:** `done`=1 and `busy`=0. A new `start` is accepted in this cycle; otherwise the state returns to IDLE.
- **Special cases (required results, independent of the iteration):**
  - Divide by zero: quotient = 0xFFFFFFFF (DIV and DIVU); remainder = op_a.
  - Signed overflow, op_a=0x80000000 and op_b=0xFFFFFFFF with DIV/REM: quotient = 0x80000000, remainder = 0.
- **flush:** from any state, the next state is IDLE, `busy`=0, and no `done` is produced. `result` keeps its previous value. flush wins over a simultaneous `start`.
- **rst:** wins over flush and start, and takes effect even mid-CALC.
- `start` while busy=1 is ignored. The pipeline is stalled in that case, so decode must hold it.

## Timing
- `start` is accepted at edge T. `busy`=1 for cycles T+1 through T+33 (32 CALC cycles + 1 SIGN cycle).
- `done`=1 and `result` are valid in cycle T+34. Start-to-done latency is therefore 34 cycles for all ops on the normal path.
- Back-to-back: a `start` in the DONE cycle (T+34) produces its `done` at T+68. There are no idle gaps.
- `busy` is a registered output, with no combinational path from `start`. Decode asserts stall in cycle T from the `start` decode itself.
- `result` changes only on the edge that enters DONE.

## Configuration
- Macro: `MULDIV_FAST_PATH_EN`.
- **Defined:** divide-by-zero and signed-overflow ops detected at accept go directly IDLE→DONE.
  - `done` and `result` arrive at T+1, with `busy` never asserted.
  - Normal ops are unchanged (34 cycles).
- **Undefined:** special cases run the full 34-cycle sequence. SIGN overrides the result with the required special value. Timing is uniform for all ops.

## Test plan
- MUL 7 × −3 (0x00000007, 0xFFFFFFFD) → `done` at T+34, `result`=0xFFFFFFEB; `busy` high exactly 33 cycles.
- MULH / MULHSU / MULHU with 0x80000000 × 0xFFFFFFFF → 0x00000000 / 0x80000000 / 0x7FFFFFFF respectively.
- DIV −7 / 2 → 0xFFFFFFFD; REM −7 / 2 → 0xFFFFFFFF; DIVU 0xFFFFFFF9 / 2 → 0x7FFFFFFC.
- DIVU 5 / 0 → 0xFFFFFFFF; REM 5 / 0 → 5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - With `MULDIV_FAST_PATH_EN`: `done` at T+1, `busy` stays 0.
  - Without it: `done` at T+34.
- Assert flush at T+10 during DIV → `busy`=0 at T+11, no `done`, `result` unchanged. A new MUL 3×4 accepted afterwards → 0x0000000C.
- Assert rst at T+20 of MULHU → all outputs 0 on the next edge. A `start` pulsed while busy is ignored, and its `result` is never produced.
